// File: rtl/wb_frame_reader.sv
// Wishbone classic read master: streams a framebuffer word by word from a
// BlockRAM slave into a small FIFO with registered head outputs.
module wb_frame_reader #(
  parameter int unsigned FRAME_WORDS = 2048,
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  output logic [31:0]                   wb_adr,
  output logic                          wb_cyc,
  output logic                          wb_stb,
  output logic                          wb_we,
  output logic [3:0]                    wb_sel,
  output logic [31:0]                   wb_dat_ms,
  input  logic [31:0]                   wb_dat_sm,
  input  logic                          wb_ack,
  output logic [31:0]                   pix_data,
  output logic                          pix_sof,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int IDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_SPACE, DRAIN} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   word_idx_q;
  logic               cyc_q;

  logic [32:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [LVL_W-1:0]   count_q;
  logic [LVL_W-1:0]   count_d;
  logic [LVL_W-1:0]   remaining;
  logic [31:0]        head_data_q;
  logic               head_sof_q;
  logic               head_valid_q;

  logic push;
  logic pop;
  logic full;
  logic flush;
  logic last_word;

  assign push      = (state_q == FETCH) & wb_ack;
  assign pop       = head_valid_q & pix_ready;
  assign full      = (count_q == LVL_W'(FIFO_DEPTH));
  assign count_d   = count_q + LVL_W'(push) - LVL_W'(pop);
  assign remaining = count_q - LVL_W'(pop);
  assign last_word = (word_idx_q == IDX_W'(FRAME_WORDS - 1));

  // Every path into IDLE empties the FIFO and rewinds the frame in that same cycle.
  assign flush = ((state_q == FETCH) & wb_ack & ~enable)
               | ((state_q == WAIT_SPACE) & ~enable)
               | ((state_q == DRAIN) & wb_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
      cyc_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            if (full) begin
              state_q <= WAIT_SPACE;
            end else begin
              state_q <= FETCH;
              cyc_q   <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (wb_ack) begin
            word_idx_q <= last_word ? '0 : word_idx_q + IDX_W'(1);
            if (!enable) begin
              state_q    <= IDLE;
              cyc_q      <= 1'b0;
              word_idx_q <= '0;
            end else if (count_d == LVL_W'(FIFO_DEPTH)) begin
              state_q <= WAIT_SPACE;
              cyc_q   <= 1'b0;
            end
          end else if (!enable) begin
            // The slave already sampled stb; keep it up until its ack returns.
            state_q <= DRAIN;
          end
        end
        WAIT_SPACE: begin
          if (!enable) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
          end else if (!full) begin
            state_q <= FETCH;
            cyc_q   <= 1'b1;
          end
        end
        DRAIN: begin
          if (wb_ack) begin
            state_q    <= IDLE;
            cyc_q      <= 1'b0;
            word_idx_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          cyc_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {word_idx_q == '0, wb_dat_sm};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_data_q  <= '0;
      head_sof_q   <= 1'b0;
      head_valid_q <= 1'b0;
    end else if (flush) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_data_q  <= '0;
      head_sof_q   <= 1'b0;
      head_valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      // Head registers: bypass the pushed word when nothing else remains.
      if (count_d == '0) begin
        head_valid_q <= 1'b0;
        head_data_q  <= '0;
        head_sof_q   <= 1'b0;
      end else if (remaining == '0) begin
        head_valid_q <= 1'b1;
        head_data_q  <= wb_dat_sm;
        head_sof_q   <= (word_idx_q == '0);
      end else if (pop) begin
        head_valid_q              <= 1'b1;
        {head_sof_q, head_data_q} <= mem_q[rd_ptr_q + PTR_W'(1)];
      end
    end
  end

  assign wb_adr     = BASE_ADR + 32'({word_idx_q, 2'b00});
  assign wb_cyc     = cyc_q;
  assign wb_stb     = cyc_q;
  assign wb_we      = 1'b0;
  assign wb_sel     = 4'hF;
  assign wb_dat_ms  = '0;
  assign pix_data   = head_data_q;
  assign pix_sof    = head_sof_q;
  assign pix_valid  = head_valid_q;
  assign fifo_level = count_q;

endmodule

// File: tb/tb_wb_frame_reader.sv
// Self-checking bench for wb_frame_reader: two instances with a behavioural
// BlockRAM slave each, directed sequences plus randomized back-pressure.
module tb_wb_frame_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: FRAME_WORDS=8, BASE_ADR=0, FIFO_DEPTH=4
  logic        rst_n, enable_a, ready_a;
  logic [31:0] adr_a, dat_ms_a, pix_data_a;
  logic        cyc_a, stb_a, we_a, pix_sof_a, pix_valid_a;
  logic [3:0]  sel_a;
  logic [2:0]  level_a;
  logic [31:0] dat_sm_a;
  logic        ack_a;

  // Instance B: FRAME_WORDS=2, BASE_ADR=0x100, FIFO_DEPTH=4
  logic        rst_b_n, enable_b, ready_b;
  logic [31:0] adr_b, dat_ms_b, pix_data_b;
  logic        cyc_b, stb_b, we_b, pix_sof_b, pix_valid_b;
  logic [3:0]  sel_b;
  logic [2:0]  level_b;
  logic [31:0] dat_sm_b;
  logic        ack_b;

  wb_frame_reader #(.FRAME_WORDS(8), .BASE_ADR(32'h0), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable_a),
    .wb_adr(adr_a), .wb_cyc(cyc_a), .wb_stb(stb_a), .wb_we(we_a), .wb_sel(sel_a),
    .wb_dat_ms(dat_ms_a), .wb_dat_sm(dat_sm_a), .wb_ack(ack_a),
    .pix_data(pix_data_a), .pix_sof(pix_sof_a), .pix_valid(pix_valid_a),
    .pix_ready(ready_a), .fifo_level(level_a)
  );

  wb_frame_reader #(.FRAME_WORDS(2), .BASE_ADR(32'h100), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .enable(enable_b),
    .wb_adr(adr_b), .wb_cyc(cyc_b), .wb_stb(stb_b), .wb_we(we_b), .wb_sel(sel_b),
    .wb_dat_ms(dat_ms_b), .wb_dat_sm(dat_sm_b), .wb_ack(ack_b),
    .pix_data(pix_data_b), .pix_sof(pix_sof_b), .pix_valid(pix_valid_b),
    .pix_ready(ready_b), .fifo_level(level_b)
  );

  // Slave memory: word i holds A000_0000 + i; ack toggles so one read per 2 cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_a    <= 1'b0;
      dat_sm_a <= '0;
    end else begin
      ack_a    <= cyc_a & stb_a & ~ack_a;
      dat_sm_a <= 32'hA000_0000 + (adr_a >> 2);
    end
  end

  always @(posedge clk or negedge rst_b_n) begin
    if (!rst_b_n) begin
      ack_b    <= 1'b0;
      dat_sm_b <= '0;
    end else begin
      ack_b    <= cyc_b & stb_b & ~ack_b;
      dat_sm_b <= 32'hA000_0000 + ((adr_b - 32'h100) >> 2);
    end
  end

  typedef struct {
    int          word;
    logic [31:0] exp_adr;
    logic [31:0] exp_data;
    logic        exp_sof;
  } vec_t;

  vec_t        tbl[9];
  int          errors = 0;
  int          checks = 0;
  int          cycle_n = 0;
  int          model_level = 0;
  bit          lvl_chk = 1'b0;
  logic [31:0] acks_a[$];
  int          ack_t[$];
  logic [32:0] pops_a[$];
  logic [31:0] acks_b[$];
  logic [32:0] pops_b[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle_n);
    end
  endtask

  // Observe everything on the falling edge, then return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    cycle_n++;
    if (ack_a && cyc_a) begin
      acks_a.push_back(adr_a);
      ack_t.push_back(cycle_n);
    end
    if (pix_valid_a && ready_a) pops_a.push_back({pix_sof_a, pix_data_a});
    if (ack_b && cyc_b) acks_b.push_back(adr_b);
    if (pix_valid_b && ready_b) pops_b.push_back({pix_sof_b, pix_data_b});
    chk("a_bus_const", {31'h0, we_a, sel_a, dat_ms_a, stb_a}, {31'h0, 1'b0, 4'hF, 32'h0, cyc_a});
    chk("b_bus_const", {31'h0, we_b, sel_b, dat_ms_b, stb_b}, {31'h0, 1'b0, 4'hF, 32'h0, cyc_b});
    chk("a_level_max", 64'(level_a <= 3'd4), 64'd1);
    if (!rst_n) begin
      model_level = 0;
    end else if (lvl_chk) begin
      chk("a_level_model", 64'(level_a), 64'(model_level));
      chk("a_valid_model", 64'(pix_valid_a), 64'(model_level != 0));
      model_level += ((ack_a && cyc_a) ? 1 : 0) - ((pix_valid_a && ready_a) ? 1 : 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acks_a.delete();
    ack_t.delete();
    pops_a.delete();
  endtask

  bit found;
  int exp_i;

  initial begin
    for (int i = 0; i < 9; i++) begin
      tbl[i].word     = i % 8;
      tbl[i].exp_adr  = 32'(4 * (i % 8));
      tbl[i].exp_data = 32'hA000_0000 + 32'(i % 8);
      tbl[i].exp_sof  = ((i % 8) == 0);
    end

    rst_n = 1'b0; rst_b_n = 1'b0;
    enable_a = 1'b0; ready_a = 1'b0; enable_b = 1'b0; ready_b = 1'b0;
    repeat (3) tick();

    chk("rst_cyc", 64'(cyc_a), 64'd0);
    chk("rst_valid", 64'(pix_valid_a), 64'd0);
    chk("rst_data", 64'(pix_data_a), 64'd0);
    chk("rst_sof", 64'(pix_sof_a), 64'd0);
    chk("rst_level", 64'(level_a), 64'd0);

    rst_n = 1'b1; rst_b_n = 1'b1;
    enable_a = 1'b1; enable_b = 1'b1; ready_b = 1'b1;

    // No consumer: exactly FIFO_DEPTH fetches, then the bus goes quiet.
    repeat (30) tick();
    chk("fill_acks", 64'(acks_a.size()), 64'd4);
    chk("fill_cyc", 64'(cyc_a), 64'd0);
    chk("fill_level", 64'(level_a), 64'd4);
    chk("fill_head", {31'h0, pix_sof_a, pix_data_a}, {31'h0, 1'b1, 32'hA000_0000});
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
    repeat (10) tick();
    chk("refill_acks", 64'(acks_a.size()), 64'd5);
    if (acks_a.size() >= 5) chk("refill_adr", 64'(acks_a[4]), 64'd16);
    chk("refill_level", 64'(level_a), 64'd4);
    chk("refill_pops", 64'(pops_a.size()), 64'd1);
    if (pops_a.size() >= 1) chk("refill_pop0", 64'(pops_a[0]), {31'h0, 1'b1, 32'hA000_0000});

    // Drop enable while a strobe is outstanding without ack.
    ready_a = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (cyc_a && !ack_a) begin found = 1'b1; break; end
      tick();
    end
    chk("drain_find", 64'(found), 64'd1);
    enable_a = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (ack_a) begin found = 1'b1; break; end
      chk("drain_stb_hold", 64'(stb_a), 64'd1);
    end
    chk("drain_ack_seen", 64'(found), 64'd1);
    chk("drain_stb_at_ack", 64'(stb_a), 64'd1);
    tick();
    chk("drain_cyc", 64'(cyc_a), 64'd0);
    chk("drain_level", 64'(level_a), 64'd0);
    chk("drain_valid", 64'(pix_valid_a), 64'd0);
    tick();

    // Re-enable with a ready consumer: stream one frame plus a wrap.
    clear_logs();
    enable_a = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (acks_a.size() >= 9 && pops_a.size() >= 9) begin found = 1'b1; break; end
    end
    chk("stream_timeout", 64'(found), 64'd1);
    for (int i = 0; i < 9; i++) begin
      if (i < acks_a.size()) chk($sformatf("stream_adr[%0d]", tbl[i].word), 64'(acks_a[i]), 64'(tbl[i].exp_adr));
      if (i < pops_a.size()) chk($sformatf("stream_pix[%0d]", tbl[i].word), 64'(pops_a[i]),
                                 {31'h0, tbl[i].exp_sof, tbl[i].exp_data});
      if (i > 0 && i < ack_t.size()) chk("stream_ack_gap", 64'(ack_t[i] - ack_t[i-1]), 64'd2);
    end

    // Asynchronous reset in the middle of a frame.
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (cyc_a && adr_a == 32'd20) begin found = 1'b1; break; end
      tick();
    end
    chk("rst_mid_find", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", 64'(cyc_a), 64'd0);
    chk("rst_mid_stb", 64'(stb_a), 64'd0);
    chk("rst_mid_valid", 64'(pix_valid_a), 64'd0);
    chk("rst_mid_data", 64'(pix_data_a), 64'd0);
    chk("rst_mid_sof", 64'(pix_sof_a), 64'd0);
    chk("rst_mid_level", 64'(level_a), 64'd0);
    tick();
    rst_n = 1'b1;
    clear_logs();
    model_level = 0;
    lvl_chk = 1'b1;

    // Random back-pressure: popped stream must be the memory sequence in order.
    for (int n = 0; n < 1000; n++) begin
      ready_a = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rand_progress", 64'(pops_a.size() > 100), 64'd1);
    for (int i = 0; i < acks_a.size(); i++)
      chk("rand_adr", 64'(acks_a[i]), 64'(4 * (i % 8)));
    for (int i = 0; i < pops_a.size(); i++) begin
      exp_i = i % 8;
      chk("rand_pix", 64'(pops_a[i]), {31'h0, exp_i == 0, 32'hA000_0000 + 32'(exp_i)});
    end

    // Two-word frame at a non-zero base.
    chk("b_acks", 64'(acks_b.size() >= 6), 64'd1);
    chk("b_pops", 64'(pops_b.size() >= 6), 64'd1);
    for (int i = 0; i < 6; i++) begin
      if (i < acks_b.size()) chk("b_adr", 64'(acks_b[i]), 64'(32'h100 + 32'(4 * (i % 2))));
      if (i < pops_b.size()) chk("b_pix", 64'(pops_b[i]), {31'h0, (i % 2) == 0, 32'hA000_0000 + 32'(i % 2)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_frame_reader.md
Name: wb_frame_reader

Overview:
- Wishbone classic read master that streams a framebuffer out of the Wishbone BlockRAM slave word by word.
- Sits directly upstream of that slave and downstream of nothing; its pixel stream feeds the video output stage.
- Fetches FRAME_WORDS consecutive 32-bit words starting at BASE_ADR, wraps to start the next frame, and buffers the words in an internal FIFO.
- The FIFO absorbs the slave's 2-cycle read latency and consumer back-pressure.

Parameters:
- FRAME_WORDS, 2048: words per frame; must be >= 2.
- BASE_ADR, 32'h0000_0000: byte address of frame word 0; must be 4-byte aligned.
- FIFO_DEPTH, 16: FIFO entries; must be a power of 2 and >= 2.

Ports:
- clk  in  1  system clock, shared with the Wishbone slave.
- rst_n  in  1  reset, asynchronous assert, active-low.
- enable  in  1  1 = stream frames; 0 = stop, flush and rewind.
- wb_adr  out  32  byte address = BASE_ADR + 4*word_idx.
- wb_cyc  out  1  bus cycle.
- wb_stb  out  1  strobe; always equal to wb_cyc.
- wb_we  out  1  constant 0.
- wb_sel  out  4  constant 4'hF.
- wb_dat_ms  out  32  constant 0.
- wb_dat_sm  in  32  read data; valid on the wb_ack cycle.
- wb_ack  in  1  slave acknowledge.
- pix_data  out  32  FIFO head data.
- pix_sof  out  1  FIFO head is frame word 0.
- pix_valid  out  1  FIFO not empty.
- pix_ready  in  1  consumer pop request.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
Reset (rst_n=0, acts immediately):
- state = IDLE, word_idx = 0, FIFO empty.
- wb_cyc = wb_stb = 0, pix_valid = 0, pix_data = 0, pix_sof = 0, fifo_level = 0.
- Reset mid-transaction abandons the transaction; no push happens.

FSM states: IDLE, FETCH, WAIT_SPACE, DRAIN.
- IDLE: cyc = stb = 0.
  - Leaves when enable = 1: to FETCH if FIFO not full, else WAIT_SPACE. After a flush the FIFO is always empty.
- FETCH: cyc = stb = 1; wb_adr held stable until wb_ack.
  - On wb_ack: push {word_idx==0, wb_dat_sm} into the FIFO.
  - word_idx increments; it wraps from FRAME_WORDS-1 to 0.
  - After the push, if the FIFO is full (occupancy == FIFO_DEPTH after that cycle's push and pop), go to WAIT_SPACE. Otherwise stay in FETCH with the new address on the next cycle.
  - If enable = 0 without wb_ack: go to DRAIN.
- WAIT_SPACE: cyc = stb = 0.
  - To FETCH when occupancy < FIFO_DEPTH.
  - enable = 0 takes priority: go to IDLE and flush.
- DRAIN: cyc = stb = 1, waiting for the outstanding ack.
  - On wb_ack: discard the data, go to IDLE and flush.
  - Never drop stb before ack; the slave's ack register must not desynchronise.

Flush:
- Takes effect on the cycle of entry into IDLE: FIFO emptied, word_idx = 0.

Throughput:
- Slave read ack arrives 1 cycle after stb is sampled with its ack register low.
- With stb held high, one word is acked every 2 cycles.
- Master advances wb_adr in the cycle after ack; the slave samples the new address on that cycle.

FIFO:
- Registered head outputs (pix_data, pix_sof, pix_valid).
- Pop occurs when pix_valid & pix_ready.
- Push into empty FIFO: pix_valid rises the next cycle.
- Simultaneous push and pop when full is impossible by construction: there is no fetch when full.
- Simultaneous push and pop at any other level: occupancy unchanged.
- pix_ready while empty: ignored.
- fifo_level = pushes minus pops, 0..FIFO_DEPTH.

Test Plan:
1. Memory preloaded with word i = 32'hA000_0000+i; FRAME_WORDS=8, enable=1, pix_ready=1 -> pix_data A0000000..A0000007 then A0000000 again. pix_sof=1 exactly on index 0 words. wb_adr sequence 0,4,..,28,0. One ack every 2 cycles.
2. pix_ready=0, FIFO_DEPTH=4 -> exactly 4 acks, then cyc=0, fifo_level=4. Raise pix_ready for 1 cycle -> one further fetch, at address 16.
3. enable dropped during FETCH with stb high and no ack yet -> stb remains 1 until ack. Then cyc=0, fifo_level=0, pix_valid=0. Re-enable -> first wb_adr = BASE_ADR, first word pix_sof=1.
4. rst_n pulsed low for 1 cycle mid-frame (word_idx=5) -> outputs zero immediately. After release with enable=1, fetch restarts at BASE_ADR.
5. BASE_ADR=32'h100, FRAME_WORDS=2 -> wb_adr alternates 0x100, 0x104. wb_we=0 and wb_sel=F throughout.
6. pix_ready toggled randomly for 1000 cycles -> output stream equals the memory sequence with no loss or duplication. fifo_level never exceeds FIFO_DEPTH.
